// File: rtl/lcd_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_ctrl
//
// Write-only controller for an HD44780-style character LCD. The core writes a
// single 32-bit register; a rising edge on its STROBE bit launches one bus
// write of RS/DATA, timed as:
//
//   SETUP (T_SETUP, EN=0) -> PULSE (T_EN, EN=1) -> HOLD (T_HOLD, EN=0)
//     -> WAIT (T_EXEC, or T_EXEC_LONG for clear/home) -> IDLE or next write
//
// A single pending slot absorbs one request that arrives while a write is in
// flight. A request that finds the slot already full is dropped and sets the
// sticky overrun flag.
//
// Ports
//   i_clk       clock
//   i_reset     asynchronous active-low reset
//   i_io_lcd    core register: [31] ON, [10] STROBE, [9] RS, [8] RW (ignored),
//               [7:0] DATA
//   o_lcd_data  LCD data bus
//   o_lcd_rs    LCD register select
//   o_lcd_rw    LCD read/write, tied to write (0)
//   o_lcd_en    LCD enable strobe
//   o_lcd_on    panel power, i_io_lcd[31] delayed by one cycle
//   o_busy      write in flight or a request pending
//   o_overrun   sticky: a request was dropped since reset
//
// Handshake: there is no ready back to the core. A request is accepted when
// it is seen (directly if idle, into the pending slot otherwise); the core
// should poll o_busy and only strobe again once o_busy is low if it must not
// lose writes. o_overrun records any loss.
//
// The FSM state is held in state_q (see the ST_* encodings) so that checkers
// can bind to it directly.
// -----------------------------------------------------------------------------
module lcd_ctrl #(
  parameter int T_SETUP     = 2,
  parameter int T_EN        = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_overrun
);

  // Counter is wide enough for the longest wait, and never narrower than 17
  // bits so the default 82000-cycle wait always fits.
  localparam int MAX_T  = (T_EXEC_LONG > T_EXEC) ? T_EXEC_LONG : T_EXEC;
  localparam int NEED_W = $clog2(MAX_T + 1);
  localparam int CNT_W  = (NEED_W > 17) ? NEED_W : 17;

  // Each phase loads (duration - 1) and leaves the phase when the count is 0,
  // so a phase of length T occupies exactly T clock cycles.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             rs_q,        rs_d;
  logic [7:0]       data_q,      data_d;
  logic             en_q,        en_d;
  logic             pend_vld_q,  pend_vld_d;
  logic             pend_rs_q,   pend_rs_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic             overrun_q,   overrun_d;
  logic             strobe_q;
  logic             armed_q;
  logic             on_q;

  // ---------------------------------------------------------------------------
  // Request detection
  // ---------------------------------------------------------------------------
  logic       req_strobe;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req;
  logic       cnt_zero;
  logic       long_cmd;
  logic       req_taken;

  assign req_strobe = i_io_lcd[10];
  assign req_rs     = i_io_lcd[9];
  assign req_data   = i_io_lcd[7:0];

  // armed_q stays low after reset until STROBE has been sampled low, so a
  // STROBE already high at reset release is not mistaken for a fresh edge.
  assign req = req_strobe & ~strobe_q & armed_q;

  assign cnt_zero = (cnt_q == '0);

  // Clear display (0x01) and return home (0x02) are the slow instructions.
  assign long_cmd = ~rs_q & ((data_q == 8'h01) | (data_q == 8'h02));

  // RW and the spare register bits are not used by a write-only controller.
  logic unused_io_bits;
  assign unused_io_bits = ^{i_io_lcd[30:11], i_io_lcd[8]};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rs_d        = rs_q;
    data_d      = data_q;
    en_d        = en_q;
    pend_vld_d  = pend_vld_q;
    pend_rs_d   = pend_rs_q;
    pend_data_d = pend_data_q;
    overrun_d   = overrun_q;
    req_taken   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d   = ST_SETUP;
          cnt_d     = LD_SETUP;
          rs_d      = req_rs;
          data_d    = req_data;
          req_taken = 1'b1;
        end
      end

      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_PULSE;
          cnt_d   = LD_EN;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = LD_HOLD;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_WAIT;
          cnt_d   = long_cmd ? LD_LONG : LD_EXEC;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_WAIT: begin
        if (cnt_zero) begin
          if (pend_vld_q) begin
            // Pending write goes first; it was queued before any new request.
            state_d    = ST_SETUP;
            cnt_d      = LD_SETUP;
            rs_d       = pend_rs_q;
            data_d     = pend_data_q;
            pend_vld_d = 1'b0;
          end else if (req) begin
            // Request landing exactly on expiry bypasses the slot.
            state_d   = ST_SETUP;
            cnt_d     = LD_SETUP;
            rs_d      = req_rs;
            data_d    = req_data;
            req_taken = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        en_d    = 1'b0;
      end
    endcase

    // Requests not taken straight into SETUP go to the pending slot. The slot
    // occupancy is judged before this edge, so a request on the same edge the
    // slot drains into SETUP is still treated as a collision and dropped.
    if (req && !req_taken) begin
      if (!pend_vld_q) begin
        pend_vld_d  = 1'b1;
        pend_rs_d   = req_rs;
        pend_data_d = req_data;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      en_q        <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= 8'h00;
      overrun_q   <= 1'b0;
      strobe_q    <= 1'b0;
      armed_q     <= 1'b0;
      on_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      en_q        <= en_d;
      pend_vld_q  <= pend_vld_d;
      pend_rs_q   <= pend_rs_d;
      pend_data_q <= pend_data_d;
      overrun_q   <= overrun_d;
      strobe_q    <= req_strobe;
      armed_q     <= armed_q | ~req_strobe;
      on_q        <= i_io_lcd[31];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;
  assign o_busy     = (state_q != ST_IDLE) | pend_vld_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_ctrl
//
// Directed bench for lcd_ctrl. The slow-instruction wait is shortened to
// 8200 cycles so the whole run stays short; every other timing parameter is
// at its default. Expected {RS,DATA} and the expected EN rising cycle are
// pushed when a request is driven; a negedge monitor pops them on every EN
// rising edge and also checks pulse width and bus stability.
// -----------------------------------------------------------------------------
module tb_lcd_ctrl;

  localparam int T_SETUP = 2;
  localparam int T_EN    = 12;
  localparam int T_HOLD  = 2;
  localparam int T_EXEC  = 2000;
  localparam int T_LONG  = 8200;
  localparam int W       = 9;
  // Edge offset from request edge to WAIT start, and to busy falling.
  localparam int T_PRE   = T_SETUP + T_EN + T_HOLD;
  localparam int T_TXN   = T_PRE + T_EXEC;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        on_b   = 1'b0;
  logic        strobe = 1'b0;
  logic        rs_b   = 1'b0;
  logic        rw_b   = 1'b0;
  logic [7:0]  data_b = 8'h00;
  logic [31:0] io;
  assign io = {on_b, 20'd0, strobe, rs_b, rw_b, data_b};

  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, busy, overrun;

  lcd_ctrl #(
    .T_SETUP    (T_SETUP),
    .T_EN       (T_EN),
    .T_HOLD     (T_HOLD),
    .T_EXEC     (T_EXEC),
    .T_EXEC_LONG(T_LONG)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_io_lcd  (io),
    .o_lcd_data(lcd_data),
    .o_lcd_rs  (lcd_rs),
    .o_lcd_rw  (lcd_rw),
    .o_lcd_en  (lcd_en),
    .o_lcd_on  (lcd_on),
    .o_busy    (busy),
    .o_overrun (overrun)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int tests_run = 0;
  int fails     = 0;
  int pulse_cnt = 0;

  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input logic r, input logic [7:0] d, input int t);
    exp_q.push_back({r, d});
    exp_t_q.push_back(t);
  endtask

  logic         en_prev  = 1'b0;
  logic         in_pulse = 1'b0;
  int           rise_cyc = 0;
  logic [W-1:0] cur_exp  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      en_prev  = 1'b0;
      in_pulse = 1'b0;
    end else begin
      if (lcd_en && !en_prev) begin
        pulse_cnt++;
        rise_cyc = cyc;
        in_pulse = 1'b1;
        if (exp_q.size() == 0) begin
          check("pulse_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          cur_exp = exp_q.pop_front();
          check("pulse_rs_data", {23'd0, lcd_rs, lcd_data}, {23'd0, cur_exp});
          check("pulse_start", cyc, exp_t_q.pop_front());
          check("pulse_rw", {31'd0, lcd_rw}, 32'd0);
        end
      end
      if (!lcd_en && en_prev && in_pulse) begin
        check("pulse_width", cyc - rise_cyc, T_EN);
        check("pulse_bus_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, cur_exp});
        in_pulse = 1'b0;
      end
      en_prev = lcd_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // One-cycle STROBE pulse; n is the edge that samples it.
  task automatic send(input logic r, input logic [7:0] d, output int n);
    rs_b   = r;
    data_b = d;
    rw_b   = 1'($urandom_range(0, 1));
    strobe = 1'b1;
    n      = cyc + 1;
    tick();
    strobe = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n, m, k, e, p0;
    logic [7:0] rd;

    // Reset: outputs forced even with ON requested.
    on_b = 1'b1;
    repeat (3) tick();
    check("rst_data",    {24'd0, lcd_data}, 32'h00);
    check("rst_rs",      {31'd0, lcd_rs},   32'd0);
    check("rst_rw",      {31'd0, lcd_rw},   32'd0);
    check("rst_en",      {31'd0, lcd_en},   32'd0);
    check("rst_on",      {31'd0, lcd_on},   32'd0);
    check("rst_busy",    {31'd0, busy},     32'd0);
    check("rst_overrun", {31'd0, overrun},  32'd0);
    on_b  = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Basic write, default timing.
    send(1'b1, 8'h41, n);
    expect_pulse(1'b1, 8'h41, n + T_SETUP);
    check("t1_rs",   {31'd0, lcd_rs}, 32'd1);
    check("t1_data", {24'd0, lcd_data}, 32'h41);
    check("t1_en_setup", {31'd0, lcd_en}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    goto_cyc(n + T_TXN - 1);
    check("t1_busy_last", {31'd0, busy}, 32'd1);
    goto_cyc(n + T_TXN);
    check("t1_busy_fall", {31'd0, busy}, 32'd0);

    // Clear command with a second request queued during its long WAIT.
    repeat (4) tick();
    send(1'b0, 8'h01, n);
    expect_pulse(1'b0, 8'h01, n + T_SETUP);
    goto_cyc(n + 100);
    send(1'b1, 8'h42, m);
    e = n + T_PRE + T_LONG;
    expect_pulse(1'b1, 8'h42, e + T_SETUP);
    check("t2_overrun", {31'd0, overrun}, 32'd0);
    check("t2_bus_held", {23'd0, lcd_rs, lcd_data}, {23'd0, 1'b0, 8'h01});
    goto_cyc(e - 1);
    check("t2_busy_long", {31'd0, busy}, 32'd1);
    check("t2_bus_long", {23'd0, lcd_rs, lcd_data}, {23'd0, 1'b0, 8'h01});
    goto_cyc(e);
    check("t2_bus_next", {23'd0, lcd_rs, lcd_data}, {23'd0, 1'b1, 8'h42});
    goto_cyc(e + T_TXN - 1);
    check("t2_busy_last", {31'd0, busy}, 32'd1);
    goto_cyc(e + T_TXN);
    check("t2_busy_fall", {31'd0, busy}, 32'd0);

    // Request exactly on WAIT expiry with the slot empty.
    repeat (4) tick();
    send(1'b1, 8'h33, n);
    expect_pulse(1'b1, 8'h33, n + T_SETUP);
    goto_cyc(n + T_TXN - 1);
    send(1'b0, 8'h38, m);
    expect_pulse(1'b0, 8'h38, m + T_SETUP);
    check("t19_edge", m, n + T_TXN);
    check("t19_busy", {31'd0, busy}, 32'd1);
    check("t19_overrun", {31'd0, overrun}, 32'd0);
    check("t19_bus", {23'd0, lcd_rs, lcd_data}, {23'd0, 1'b0, 8'h38});
    goto_cyc(m + T_TXN);
    check("t19_busy_fall", {31'd0, busy}, 32'd0);

    // Three requests in one transaction: second queued, third dropped.
    repeat (4) tick();
    rd = 8'($urandom_range(8'h20, 8'h7e));
    send(1'b1, rd, n);
    expect_pulse(1'b1, rd, n + T_SETUP);
    goto_cyc(n + 3);
    send(1'b1, rd ^ 8'h80, m);
    expect_pulse(1'b1, rd ^ 8'h80, n + T_TXN + T_SETUP);
    check("t3_no_overrun", {31'd0, overrun}, 32'd0);
    goto_cyc(n + 6);
    send(1'b1, 8'h63, k);
    check("t3_overrun", {31'd0, overrun}, 32'd1);
    goto_cyc(n + T_TXN);
    check("t3_second", {24'd0, lcd_data}, {24'd0, rd ^ 8'h80});
    goto_cyc(n + 2 * T_TXN);
    check("t3_busy_fall", {31'd0, busy}, 32'd0);
    check("t3_overrun_sticky", {31'd0, overrun}, 32'd1);

    // STROBE held high: one write only.
    repeat (4) tick();
    p0     = pulse_cnt;
    rs_b   = 1'b1;
    data_b = 8'h55;
    strobe = 1'b1;
    n      = cyc + 1;
    expect_pulse(1'b1, 8'h55, n + T_SETUP);
    repeat (5000) tick();
    strobe = 1'b0;
    repeat (20) tick();
    check("t4_one_pulse", pulse_cnt - p0, 1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_overrun_sticky", {31'd0, overrun}, 32'd1);

    // Reset during PULSE with a request pending.
    send(1'b1, 8'h50, n);
    expect_pulse(1'b1, 8'h50, n + T_SETUP);
    goto_cyc(n + 3);
    send(1'b1, 8'h51, m);
    goto_cyc(n + 6);
    check("t5_en_before", {31'd0, lcd_en}, 32'd1);
    p0     = pulse_cnt;
    rst_n  = 1'b0;
    strobe = 1'b1;
    #1;
    check("t5_en_async",   {31'd0, lcd_en},   32'd0);
    check("t5_busy_async", {31'd0, busy},     32'd0);
    check("t5_ovr_async",  {31'd0, overrun},  32'd0);
    check("t5_data_async", {23'd0, lcd_rs, lcd_data}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("t5_held_strobe", {31'd0, busy}, 32'd0);
    strobe = 1'b0;
    goto_cyc(cyc + T_TXN + 50);
    check("t5_no_pulse", pulse_cnt - p0, 0);
    check("t5_busy_idle", {31'd0, busy}, 32'd0);
    send(1'b1, 8'h77, n);
    expect_pulse(1'b1, 8'h77, n + T_SETUP);
    goto_cyc(n + T_TXN);
    check("t5_after_busy", {31'd0, busy}, 32'd0);

    // Panel power follows bit 31 one cycle later, no EN activity.
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      on_b = ~on_b;
      check("t6_on_before", {31'd0, lcd_on}, {31'd0, ~on_b});
      tick();
      check("t6_on_after", {31'd0, lcd_on}, {31'd0, on_b});
    end
    repeat (5) tick();
    check("t6_no_pulse", pulse_cnt - p0, 0);
    check("t6_busy", {31'd0, busy}, 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL provide parameter T_SETUP, default 2: cycles of RS/DATA setup before EN rises.
REQ-002 SHALL provide parameter T_EN, default 12: cycles EN is held high.
REQ-003 SHALL provide parameter T_HOLD, default 2: cycles of RS/DATA hold after EN falls.
REQ-004 SHALL provide parameter T_EXEC, default 2000: command execution wait in cycles, normal commands.
REQ-005 SHALL provide parameter T_EXEC_LONG, default 82000: execution wait in cycles for clear (0x01) and home (0x02) commands.
REQ-006 SHALL have a single clock domain; reset is asynchronous and active-low.
REQ-007 SHALL have the following ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-low reset.
- i_io_lcd  in  32  core LCD register: [31] ON, [10] STROBE, [9] RS, [8] RW, [7:0] DATA.
- o_lcd_data  out  8  LCD data bus.
- o_lcd_rs  out  1  register select.
- o_lcd_rw  out  1  read/write; always 0.
- o_lcd_en  out  1  LCD enable strobe.
- o_lcd_on  out  1  panel power.
- o_busy  out  1  transaction in progress or pending.
- o_overrun  out  1  sticky: a request was dropped.

Function
REQ-008 SHALL register i_io_lcd[31] to o_lcd_on with 1-cycle latency.
REQ-009 SHALL register STROBE each cycle; a request is a sampled 0->1 transition. Level-high STROBE SHALL NOT retrigger.
REQ-010 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD and WAIT, with one down-counter of at least 17 bits.
REQ-011 In IDLE, on a request at edge N, SHALL latch RS and DATA and enter SETUP at edge N; o_lcd_rs and o_lcd_data SHALL take the latched values at edge N.
REQ-012 SETUP SHALL last T_SETUP cycles with EN=0; then PULSE.
REQ-013 PULSE SHALL last T_EN cycles with EN=1, so o_lcd_en is high from edge N+T_SETUP for exactly T_EN cycles; then HOLD.
REQ-014 HOLD SHALL last T_HOLD cycles with EN=0 and RS/DATA unchanged; then WAIT.
REQ-015 WAIT SHALL last T_EXEC_LONG cycles if the latched RS=0 and DATA is 0x01 or 0x02; otherwise it SHALL last T_EXEC cycles.
REQ-016 On WAIT expiry, if the pending slot is full, SHALL move it to the active transaction, clear the slot, and enter SETUP; otherwise SHALL enter IDLE.
REQ-017 SHALL hold a one-deep pending slot (RS and DATA). A request in any state other than IDLE SHALL fill the slot if it is empty.
REQ-018 A request that arrives while the pending slot is full SHALL be dropped and SHALL set o_overrun, which stays set until reset.
REQ-019 If a request coincides with WAIT expiry while the slot is empty, the request SHALL be serviced directly into SETUP at that edge, with no loss and no overrun.
REQ-020 o_busy SHALL be 1 whenever the FSM is not in IDLE or the pending slot is full.
REQ-021 i_io_lcd[8] (RW) SHALL be ignored; reads are not supported.
REQ-022 o_lcd_rs and o_lcd_data SHALL change only on entry to SETUP.

Reset
REQ-023 While i_reset=0, SHALL asynchronously force state IDLE, counter 0, pending slot empty and STROBE sample 0.
REQ-024 While i_reset=0, SHALL asynchronously force o_lcd_data=0x00, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0, o_busy=0 and o_overrun=0.
REQ-025 Reset asserted mid-transaction SHALL drop EN immediately and discard both the active and the pending request.
REQ-026 After release, SHALL NOT detect a request while STROBE is held high until STROBE has been seen low.

Verification
REQ-027 Defaults; STROBE 0->1 with RS=1, DATA=0x41 at edge N -> o_lcd_rs=1, o_lcd_data=0x41 from edge N; o_lcd_en high for cycles N+2..N+13; o_busy falls at N+2016.
REQ-028 RS=0, DATA=0x01 -> WAIT lasts 82000 cycles; a second request RS=1, DATA=0x42 issued during that WAIT -> its EN pulse begins exactly T_SETUP cycles after the first transaction's WAIT ends.
REQ-029 Three requests inside one transaction -> the second is serviced, the third is dropped, and o_overrun=1 persists.
REQ-030 STROBE held high for 5000 cycles -> exactly one EN pulse.
REQ-031 i_reset pulsed low during PULSE -> o_lcd_en=0 asynchronously, o_busy=0, and no further EN pulse occurs even if a request was pending.
REQ-032 Toggling i_io_lcd[31] -> o_lcd_on follows one cycle later, with no EN activity.
